// File: rtl/dlfloat16_decoder_unit.sv
// Instruction decoder for the DLFloat16 unit: turns a 32-bit instruction word into registered
// unit-select, operand-index and control fields; anything not recognised decodes to a NOP.
module dlfloat16_decoder_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic [3:0]  ena,
    output logic [2:0]  rm,
    output logic [2:0]  sel2,
    output logic        op,
    output logic [1:0]  sel1,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rs3,
    output logic [4:0]  rd,
    output logic [11:0] imm,
    output logic        wr_enable,
    output logic        mem_read,
    output logic        mem_write,
    output logic        s_1,
    output logic        s_2,
    output logic        sp
);

    localparam logic [6:0] OpcFp    = 7'b1011011;
    localparam logic [6:0] OpcFmadd = 7'b0011011;
    localparam logic [6:0] OpcFmsub = 7'b0111011;
    localparam logic [6:0] OpcLoad  = 7'b0001011;
    localparam logic [6:0] OpcStore = 7'b0101011;

    logic [4:0] funct5;
    logic [2:0] funct3;
    logic [6:0] opcode;

    assign funct5 = instr[31:27];
    assign funct3 = instr[14:12];
    assign opcode = instr[6:0];

    logic [3:0]  ena_d;
    logic [2:0]  rm_d;
    logic [2:0]  sel2_d;
    logic        op_d;
    logic [1:0]  sel1_d;
    logic [4:0]  rs1_d;
    logic [4:0]  rs2_d;
    logic [4:0]  rs3_d;
    logic [4:0]  rd_d;
    logic [11:0] imm_d;
    logic        wr_enable_d;
    logic        mem_read_d;
    logic        mem_write_d;
    logic        s_1_d;
    logic        s_2_d;
    logic        sp_d;
    logic        fp_legal;

    always_comb begin
        ena_d       = '0;
        rm_d        = '0;
        sel2_d      = '0;
        op_d        = 1'b0;
        sel1_d      = '0;
        rs1_d       = instr[19:15];
        rs2_d       = instr[24:20];
        rs3_d       = '0;
        rd_d        = instr[11:7];
        imm_d       = '0;
        wr_enable_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        s_1_d       = 1'b0;
        s_2_d       = 1'b0;
        sp_d        = 1'b0;
        fp_legal    = 1'b1;

        case (opcode)
            OpcFp: begin
                case (funct5)
                    5'b00000: ena_d = 4'd1;
                    5'b00001: begin
                        ena_d = 4'd1;
                        op_d  = 1'b1;
                    end
                    5'b00010: ena_d = 4'd2;
                    5'b00011: ena_d = 4'd3;
                    5'b01011: ena_d = 4'd4;
                    5'b00100: begin
                        ena_d    = 4'd5;
                        sel2_d   = funct3;
                        fp_legal = (funct3 <= 3'b010);
                    end
                    5'b00101: begin
                        ena_d    = 4'd6;
                        sel2_d   = funct3;
                        fp_legal = (funct3 <= 3'b001);
                    end
                    5'b01000: begin
                        ena_d  = 4'd7;
                        sel1_d = 2'b10;
                        s_2_d  = 1'b1;
                    end
                    5'b01001: begin
                        ena_d = 4'd8;
                        s_1_d = 1'b1;
                    end
                    5'b10100: begin
                        ena_d    = 4'd9;
                        sel2_d   = funct3;
                        sel1_d   = 2'b10;
                        s_2_d    = 1'b1;
                        fp_legal = (funct3 <= 3'b010);
                    end
                    default: fp_legal = 1'b0;
                endcase

                // Unknown funct5 or an out-of-range sub-op collapses to a NOP.
                if (fp_legal) begin
                    rm_d        = funct3;
                    sp_d        = instr[25];
                    wr_enable_d = 1'b1;
                end else begin
                    ena_d  = '0;
                    op_d   = 1'b0;
                    sel1_d = '0;
                    sel2_d = '0;
                    s_1_d  = 1'b0;
                    s_2_d  = 1'b0;
                end
            end
            OpcFmadd, OpcFmsub: begin
                ena_d       = 4'd10;
                op_d        = (opcode == OpcFmsub);
                rs3_d       = instr[31:27];
                rm_d        = funct3;
                sp_d        = instr[25];
                wr_enable_d = 1'b1;
            end
            OpcLoad: begin
                ena_d       = 4'd11;
                mem_read_d  = 1'b1;
                sel1_d      = 2'b01;
                wr_enable_d = 1'b1;
                s_1_d       = 1'b1;
                imm_d       = instr[31:20];
                rs2_d       = '0;
            end
            OpcStore: begin
                ena_d       = 4'd12;
                mem_write_d = 1'b1;
                s_1_d       = 1'b1;
                imm_d       = {instr[31:25], instr[11:7]};
                rd_d        = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena       <= '0;
            rm        <= '0;
            sel2      <= '0;
            op        <= 1'b0;
            sel1      <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rs3       <= '0;
            rd        <= '0;
            imm       <= '0;
            wr_enable <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            s_1       <= 1'b0;
            s_2       <= 1'b0;
            sp        <= 1'b0;
        end else begin
            ena       <= ena_d;
            rm        <= rm_d;
            sel2      <= sel2_d;
            op        <= op_d;
            sel1      <= sel1_d;
            rs1       <= rs1_d;
            rs2       <= rs2_d;
            rs3       <= rs3_d;
            rd        <= rd_d;
            imm       <= imm_d;
            wr_enable <= wr_enable_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            s_1       <= s_1_d;
            s_2       <= s_2_d;
            sp        <= sp_d;
        end
    end

endmodule

// File: tb/tb_dlfloat16_decoder_unit.sv
// Self-checking bench for dlfloat16_decoder_unit: directed vectors plus randomized words
// checked against a table-driven reference decoder.
module tb_dlfloat16_decoder_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [3:0]  ena;
    logic [2:0]  rm;
    logic [2:0]  sel2;
    logic        op;
    logic [1:0]  sel1;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rs3;
    logic [4:0]  rd;
    logic [11:0] imm;
    logic        wr_enable;
    logic        mem_read;
    logic        mem_write;
    logic        s_1;
    logic        s_2;
    logic        sp;

    int unsigned checks = 0;
    int unsigned errors = 0;

    dlfloat16_decoder_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .ena       (ena),
        .rm        (rm),
        .sel2      (sel2),
        .op        (op),
        .sel1      (sel1),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs3       (rs3),
        .rd        (rd),
        .imm       (imm),
        .wr_enable (wr_enable),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .s_1       (s_1),
        .s_2       (s_2),
        .sp        (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [50:0] dut_vec;
    assign dut_vec = {ena, rm, sel2, op, sel1, rs1, rs2, rs3, rd, imm,
                      wr_enable, mem_read, mem_write, s_1, s_2, sp};

    // kind: 0 plain arith, 1 uses sel2, 2 result to int file, 3 operand from int file, 4 compare
    typedef struct packed {
        logic [4:0] f5;
        logic [3:0] ena;
        logic       op;
        logic [3:0] nf3;
        logic [2:0] kind;
    } fp_ent_t;

    fp_ent_t fp_tab [10];

    localparam logic [6:0] FP  = 7'b1011011;
    localparam logic [6:0] FMA = 7'b0011011;
    localparam logic [6:0] FMS = 7'b0111011;
    localparam logic [6:0] LD  = 7'b0001011;
    localparam logic [6:0] ST  = 7'b0101011;

    function automatic logic [50:0] model(input logic [31:0] w);
        logic [3:0]  e;
        logic [2:0]  r, s2sel;
        logic        o, wr, mr, mw, i1, i2, p;
        logic [1:0]  s1sel;
        logic [4:0]  a, b, c, d;
        logic [11:0] im;
        logic [2:0]  f3;
        e = 0; r = 0; s2sel = 0; o = 0; wr = 0; mr = 0; mw = 0; i1 = 0; i2 = 0; p = 0;
        s1sel = 0; c = 0; im = 0;
        a = w[19:15]; b = w[24:20]; d = w[11:7]; f3 = w[14:12];
        if (w[6:0] == FP) begin
            for (int i = 0; i < 10; i++) begin
                if (fp_tab[i].f5 == w[31:27] && {1'b0, f3} < fp_tab[i].nf3) begin
                    e = fp_tab[i].ena;
                    o = fp_tab[i].op;
                    r = f3;
                    p = w[25];
                    wr = 1;
                    if (fp_tab[i].kind == 1 || fp_tab[i].kind == 4) s2sel = f3;
                    if (fp_tab[i].kind == 2 || fp_tab[i].kind == 4) begin
                        s1sel = 2'b10;
                        i2 = 1;
                    end
                    if (fp_tab[i].kind == 3) i1 = 1;
                end
            end
        end else if (w[6:0] == FMA || w[6:0] == FMS) begin
            e = 4'd10; o = (w[6:0] == FMS); c = w[31:27]; r = f3; p = w[25]; wr = 1;
        end else if (w[6:0] == LD) begin
            e = 4'd11; mr = 1; s1sel = 2'b01; wr = 1; i1 = 1; im = w[31:20]; b = 0;
        end else if (w[6:0] == ST) begin
            e = 4'd12; mw = 1; i1 = 1; im = {w[31:25], w[11:7]}; d = 0;
        end
        return {e, r, s2sel, o, s1sel, a, b, c, d, im, wr, mr, mw, i1, i2, p};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (instr %h)", tag, got, exp, instr);
        end
    endtask

    task automatic apply(input logic [31:0] w, input string tag);
        @(negedge clk);
        instr = w;
        @(posedge clk);
        #1;
        check(tag, {13'd0, dut_vec}, {13'd0, model(w)});
    endtask

    logic [31:0] w;

    initial begin
        fp_tab[0] = '{5'b00000, 4'd1, 1'b0, 4'd8, 3'd0};
        fp_tab[1] = '{5'b00001, 4'd1, 1'b1, 4'd8, 3'd0};
        fp_tab[2] = '{5'b00010, 4'd2, 1'b0, 4'd8, 3'd0};
        fp_tab[3] = '{5'b00011, 4'd3, 1'b0, 4'd8, 3'd0};
        fp_tab[4] = '{5'b01011, 4'd4, 1'b0, 4'd8, 3'd0};
        fp_tab[5] = '{5'b00100, 4'd5, 1'b0, 4'd3, 3'd1};
        fp_tab[6] = '{5'b00101, 4'd6, 1'b0, 4'd2, 3'd1};
        fp_tab[7] = '{5'b01000, 4'd7, 1'b0, 4'd8, 3'd2};
        fp_tab[8] = '{5'b01001, 4'd8, 1'b0, 4'd8, 3'd3};
        fp_tab[9] = '{5'b10100, 4'd9, 1'b0, 4'd3, 3'd4};

        rst_n = 1'b0;
        instr = 32'h0000_005B;
        #1;
        check("reset_init", {13'd0, dut_vec}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", {13'd0, dut_vec}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add
        w = {5'b00000, 2'b00, 5'd2, 5'd1, 3'b000, 5'd4, FP};
        apply(w, "add");
        check("add_ena", {60'd0, ena}, 64'd1);
        check("add_rd", {59'd0, rd}, 64'd4);
        check("add_wr", {63'd0, wr_enable}, 64'd1);

        // Rounding-mode sweep
        for (int f = 0; f < 7; f++) begin
            w = {5'b00000, 2'b00, 5'd2, 5'd1, 3'(f), 5'd4, FP};
            apply(w, "rm_sweep");
            check("rm_value", {61'd0, rm}, 64'(f));
            check("rm_ena", {60'd0, ena}, 64'd1);
        end

        // Compare eq
        w = {5'b10100, 2'b00, 5'd1, 5'd0, 3'b010, 5'd4, FP};
        apply(w, "cmp_eq");
        check("cmp_ena", {60'd0, ena}, 64'd9);
        check("cmp_sel", {59'd0, sel2, sel1}, {59'd0, 3'b010, 2'b10});
        check("cmp_s2", {63'd0, s_2}, 64'd1);

        // Memory
        apply(32'h0000_000B, "load");
        check("load_ctl", {60'd0, ena}, 64'd11);
        check("load_flags", {61'd0, mem_read, wr_enable, s_1}, 64'b111);
        w = {7'b0000000, 5'd8, 5'd0, 3'b000, 5'd0, ST};
        apply(w, "store");
        check("store_ctl", {60'd0, ena}, 64'd12);
        check("store_flags", {61'd0, mem_write, wr_enable, rs2 == 5'd8}, 64'b101);

        // Fused
        w = {5'b00100, 2'b00, 5'd3, 5'd2, 3'b000, 5'd4, FMA};
        apply(w, "fmadd");
        check("fmadd_rs3", {59'd0, rs3}, 64'd4);
        check("fmadd_op", {63'd0, op}, 64'd0);
        w[6:0] = FMS;
        apply(w, "fmsub");
        check("fmsub_op", {63'd0, op}, 64'd1);

        // Illegal encodings
        w = {5'b11111, 2'b00, 5'd3, 5'd2, 3'b000, 5'd1, FP};
        apply(w, "bad_funct5");
        check("bad_f5_ena", {60'd0, ena}, 64'd0);
        check("bad_f5_wr", {63'd0, wr_enable}, 64'd0);
        w = {5'b00100, 2'b01, 5'd3, 5'd2, 3'b011, 5'd1, FP};
        apply(w, "bad_sgnj_f3");
        w = {5'b00101, 2'b01, 5'd3, 5'd2, 3'b010, 5'd1, FP};
        apply(w, "bad_minmax_f3");

        // Reset in the middle of traffic, no clock edge involved
        w = {5'b00001, 2'b01, 5'd7, 5'd9, 3'b011, 5'd5, FP};
        apply(w, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", {13'd0, dut_vec}, 64'd0);
        @(negedge clk);
        instr = w;
        @(posedge clk);
        #1;
        check("reset_discard", {13'd0, dut_vec}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", {13'd0, dut_vec}, {13'd0, model(w)});

        // Randomized words biased toward legal encodings
        for (int n = 0; n < 400; n++) begin
            w = $urandom;
            case ($urandom_range(0, 5))
                0: begin
                    w[6:0] = FP;
                    if ($urandom_range(0, 9) < 8) w[31:27] = fp_tab[$urandom_range(0, 9)].f5;
                end
                1: w[6:0] = FMA;
                2: w[6:0] = FMS;
                3: w[6:0] = LD;
                4: w[6:0] = ST;
                default: ;
            endcase
            apply(w, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
